// File: rtl/pico_pkg.sv
// Shared picoMips constants: switch count, handshake bit index, default debounce length.
package pico_pkg;

  localparam int unsigned NUM_SW           = 9;
  localparam int unsigned HS_BIT           = 8;
  localparam int unsigned DEBOUNCE_DEFAULT = 50000;

endpackage

// File: rtl/sw_debounce_bit.sv
// One switch channel: 2-flop synchroniser, persistence counter, clean level and edge pulses.
module sw_debounce_bit #(
  parameter int unsigned DEBOUNCE = 50000
) (
  input  logic Clock,
  input  logic nReset,
  input  logic raw,
  output logic clean,
  output logic rise,
  output logic fall,
  output logic busy_c
);

  localparam int unsigned         CNT_W    = $clog2(DEBOUNCE + 1);
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(DEBOUNCE - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;
  logic             done_c;

  // Count completes on this edge: the synchronised level has disagreed long enough.
  assign done_c = (sync2 != clean) && (cnt == CNT_LAST);
  assign busy_c = (cnt != '0);

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      clean <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      rise  <= done_c && sync2;
      fall  <= done_c && !sync2;
      if (sync2 == clean) begin
        cnt <= '0;
      end else if (done_c) begin
        clean <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/sw_conditioner.sv
// Board switch input stage: per-bit synchronise + debounce, handshake edge pulses, busy flag.
module sw_conditioner #(
  parameter int unsigned N_SW     = pico_pkg::NUM_SW,
  parameter int unsigned HS_BIT   = pico_pkg::HS_BIT,
  parameter int unsigned DEBOUNCE = pico_pkg::DEBOUNCE_DEFAULT
) (
  input  logic            Clock,
  input  logic            nReset,
  input  logic [N_SW-1:0] sw_raw,
  output logic [N_SW-1:0] sw_clean,
  output logic            hs_rise,
  output logic            hs_fall,
  output logic            busy
);

  localparam logic [N_SW-1:0] HS_MASK = N_SW'(1) << HS_BIT;

  logic [N_SW-1:0] rise_v;
  logic [N_SW-1:0] fall_v;
  logic [N_SW-1:0] busy_v;

  for (genvar i = 0; i < N_SW; i++) begin : g_bit
    sw_debounce_bit #(
      .DEBOUNCE (DEBOUNCE)
    ) u_bit (
      .Clock  (Clock),
      .nReset (nReset),
      .raw    (sw_raw[i]),
      .clean  (sw_clean[i]),
      .rise   (rise_v[i]),
      .fall   (fall_v[i]),
      .busy_c (busy_v[i])
    );
  end

  // Only the handshake channel's pulses leave the block; the rest are pruned.
  assign hs_rise = |(rise_v & HS_MASK);
  assign hs_fall = |(fall_v & HS_MASK);

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      busy <= 1'b0;
    end else begin
      busy <= |busy_v;
    end
  end

endmodule

// File: tb/tb_sw_conditioner.sv
// Directed bench for sw_conditioner with DEBOUNCE=4: vector table plus multi-cycle sequences.
module tb_sw_conditioner;

  logic       Clock  = 1'b0;
  logic       nReset = 1'b0;
  logic [8:0] sw_raw = 9'h1FF;
  logic [8:0] sw_clean;
  logic       hs_rise;
  logic       hs_fall;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  always #5 Clock = ~Clock;

  sw_conditioner #(
    .N_SW     (9),
    .HS_BIT   (8),
    .DEBOUNCE (4)
  ) dut (
    .Clock    (Clock),
    .nReset   (nReset),
    .sw_raw   (sw_raw),
    .sw_clean (sw_clean),
    .hs_rise  (hs_rise),
    .hs_fall  (hs_fall),
    .busy     (busy)
  );

  typedef struct {
    logic [8:0] raw;
    logic [8:0] clean;
    logic       rise;
    logic       fall;
    logic       busy;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic add(input logic [8:0] raw, input logic [8:0] clean,
                     input logic r, input logic f, input logic b);
    vec_t v;
    v.raw = raw; v.clean = clean; v.rise = r; v.fall = f; v.busy = b;
    vecs.push_back(v);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_clean"}, 32'(sw_clean), 32'h0);
    chk({name, "_rise"},  32'(hs_rise),  32'h0);
    chk({name, "_fall"},  32'(hs_fall),  32'h0);
    chk({name, "_busy"},  32'(busy),     32'h0);
  endtask

  initial begin
    // Power-up with all switches high, then 1FF->000, 000->0A5, and a 3-cycle glitch on bit 3.
    add(9'h1FF, 9'h000, 0, 0, 0); add(9'h1FF, 9'h000, 0, 0, 0);
    add(9'h1FF, 9'h000, 0, 0, 0); add(9'h1FF, 9'h000, 0, 0, 1);
    add(9'h1FF, 9'h000, 0, 0, 1); add(9'h1FF, 9'h1FF, 1, 0, 1);
    add(9'h1FF, 9'h1FF, 0, 0, 0); add(9'h1FF, 9'h1FF, 0, 0, 0);
    add(9'h000, 9'h1FF, 0, 0, 0); add(9'h000, 9'h1FF, 0, 0, 0);
    add(9'h000, 9'h1FF, 0, 0, 0); add(9'h000, 9'h1FF, 0, 0, 1);
    add(9'h000, 9'h1FF, 0, 0, 1); add(9'h000, 9'h000, 0, 1, 1);
    add(9'h000, 9'h000, 0, 0, 0);
    add(9'h0A5, 9'h000, 0, 0, 0); add(9'h0A5, 9'h000, 0, 0, 0);
    add(9'h0A5, 9'h000, 0, 0, 0); add(9'h0A5, 9'h000, 0, 0, 1);
    add(9'h0A5, 9'h000, 0, 0, 1); add(9'h0A5, 9'h0A5, 0, 0, 1);
    add(9'h0A5, 9'h0A5, 0, 0, 0);
    add(9'h0AD, 9'h0A5, 0, 0, 0); add(9'h0AD, 9'h0A5, 0, 0, 0);
    add(9'h0AD, 9'h0A5, 0, 0, 0); add(9'h0A5, 9'h0A5, 0, 0, 1);
    add(9'h0A5, 9'h0A5, 0, 0, 1); add(9'h0A5, 9'h0A5, 0, 0, 1);
    add(9'h0A5, 9'h0A5, 0, 0, 0); add(9'h0A5, 9'h0A5, 0, 0, 0);

    #1;
    chk_all_zero("reset_t0");
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all_zero("reset_hold");
    end
    nReset = 1'b1;

    foreach (vecs[i]) begin
      sw_raw = vecs[i].raw;
      tick();
      chk($sformatf("vec%0d_clean", i), 32'(sw_clean), 32'(vecs[i].clean));
      chk($sformatf("vec%0d_rise", i),  32'(hs_rise),  32'(vecs[i].rise));
      chk($sformatf("vec%0d_fall", i),  32'(hs_fall),  32'(vecs[i].fall));
      chk($sformatf("vec%0d_busy", i),  32'(busy),     32'(vecs[i].busy));
    end

    // Bounce on SW8: 2-cycle runs never complete a count; final level lands 5 edges later.
    begin
      logic [8:0] seq [9];
      int rises;
      seq = '{9'h1A5, 9'h1A5, 9'h0A5, 9'h0A5, 9'h1A5, 9'h1A5, 9'h0A5, 9'h0A5, 9'h1A5};
      rises = 0;
      foreach (seq[i]) begin
        sw_raw = seq[i];
        tick();
        chk("bounce_hold_clean", 32'(sw_clean), 32'h0A5);
        chk("bounce_hold_rise", 32'(hs_rise), 32'h0);
      end
      for (int k = 1; k <= 8; k++) begin
        tick();
        if (hs_rise) rises++;
        chk($sformatf("bounce_k%0d_clean8", k), 32'(sw_clean[8]), 32'(k >= 5));
        chk($sformatf("bounce_k%0d_rise", k), 32'(hs_rise), 32'(k == 5));
      end
      chk("bounce_rise_count", 32'(rises), 32'd1);
    end

    // Handshake fall: one-cycle hs_fall coincident with sw_clean[8] dropping.
    sw_raw = 9'h0A5;
    tick();
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk($sformatf("fall_k%0d_clean8", k), 32'(sw_clean[8]), 32'(k < 5));
      chk($sformatf("fall_k%0d_fall", k), 32'(hs_fall), 32'(k == 5));
      chk($sformatf("fall_k%0d_rise", k), 32'(hs_rise), 32'h0);
    end

    // Reset mid-count: progress is discarded and the full latency restarts.
    sw_raw = 9'h1A5;
    for (int k = 0; k < 4; k++) tick();
    chk("midcnt_busy_before", 32'(busy), 32'h1);
    chk("midcnt_clean_before", 32'(sw_clean), 32'h0A5);
    nReset = 1'b0;
    #1;
    chk_all_zero("midcnt_async");
    tick();
    chk_all_zero("midcnt_hold");
    nReset = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk($sformatf("restart_k%0d_clean", k), 32'(sw_clean), (k >= 6) ? 32'h1A5 : 32'h0);
      chk($sformatf("restart_k%0d_rise", k), 32'(hs_rise), 32'(k == 6));
      chk($sformatf("restart_k%0d_fall", k), 32'(hs_fall), 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
